// File: rtl/fifo_bus_ctrl.sv
// FT245 parallel FIFO bus sequencer: arbitrates keyboard reads against terminal
// writes, generates RD#/WR strobes and owns the tri-state control of the data bus.
module fifo_bus_ctrl #(
  parameter int RD_CYCLES  = 2,
  parameter int WR_CYCLES  = 2,
  parameter int REC_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       fifo_rxf,
  input  logic       fifo_txe,
  output logic       fifo_rd,
  output logic       fifo_wr,
  inout  wire  [7:0] fifo_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_take,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ack,
  output logic       busy
);

  localparam int CW = 8;

  typedef enum logic [2:0] {IDLE, RD, WR_SU, WR, WR_HD, REC} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rxf_s1, rxf_s2, txe_s1, txe_s2;
  logic          last_rx;
  logic          rx_elig, tx_elig, grant_rx, grant_tx, capture;
  logic          rd_n, wr_n, oe_n, ack_n, busy_n;
  logic          oe;
  logic [7:0]    dout;

  // FT245 flags are asynchronous; only the second flop is ever looked at
  always_ff @(posedge clk) begin
    if (reset) begin
      rxf_s1 <= 1'b1;
      rxf_s2 <= 1'b1;
      txe_s1 <= 1'b1;
      txe_s2 <= 1'b1;
    end else begin
      rxf_s1 <= fifo_rxf;
      rxf_s2 <= rxf_s1;
      txe_s1 <= fifo_txe;
      txe_s2 <= txe_s1;
    end
  end

  assign rx_elig = !rxf_s2 && (!rx_valid || rx_take);
  assign tx_elig = tx_valid && !txe_s2;
  assign capture = (state == RD) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    grant_rx = 1'b0;
    grant_tx = 1'b0;
    case (state)
      IDLE: begin
        // on a tie the side that did not win last time goes first
        if (rx_elig && (!tx_elig || !last_rx)) begin
          grant_rx = 1'b1;
          state_n  = RD;
          cnt_n    = CW'(RD_CYCLES - 1);
        end else if (tx_elig) begin
          grant_tx = 1'b1;
          state_n  = WR_SU;
        end
      end
      RD: begin
        if (cnt == '0) begin
          state_n = REC;
          cnt_n   = CW'(REC_CYCLES - 1);
        end else cnt_n = cnt - 1'b1;
      end
      WR_SU: begin
        state_n = WR;
        cnt_n   = CW'(WR_CYCLES - 1);
      end
      WR: begin
        if (cnt == '0) state_n = WR_HD;
        else cnt_n = cnt - 1'b1;
      end
      WR_HD: begin
        state_n = REC;
        cnt_n   = CW'(REC_CYCLES - 1);
      end
      REC: begin
        if (cnt == '0) state_n = IDLE;
        else cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // outputs are decoded from the next state so the pins themselves are flops
  always_comb begin
    rd_n   = (state_n != RD);
    wr_n   = (state_n == WR);
    oe_n   = (state_n == WR_SU) || (state_n == WR) || (state_n == WR_HD);
    ack_n  = (state == WR) && (state_n == WR_HD);
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_rd <= 1'b1;
      fifo_wr <= 1'b0;
      oe      <= 1'b0;
      tx_ack  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      fifo_rd <= rd_n;
      fifo_wr <= wr_n;
      oe      <= oe_n;
      tx_ack  <= ack_n;
      busy    <= busy_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout    <= 8'h00;
      last_rx <= 1'b0;
    end else begin
      if (grant_tx) dout <= tx_data;
      if (grant_rx) last_rx <= 1'b1;
      else if (grant_tx) last_rx <= 1'b0;
    end
  end

  // clear beats a capture; a capture beats a pop on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (clear) begin
      rx_valid <= 1'b0;
    end else if (capture) begin
      rx_data  <= fifo_data;
      rx_valid <= 1'b1;
    end else if (rx_take) begin
      rx_valid <= 1'b0;
    end
  end

  assign fifo_data = oe ? dout : 8'hzz;

endmodule

// File: tb/tb_fifo_bus_ctrl.sv
// Directed bench for fifo_bus_ctrl: RX/TX sequencing, tie arbitration, holding
// register full, clear collision and reset during a write.
module tb_fifo_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset, clear, fifo_rxf, fifo_txe, rx_take, tx_valid;
  logic [7:0] tx_data, bus_val;
  wire  [7:0] fifo_data;
  logic       fifo_rd, fifo_wr, rx_valid, tx_ack, busy;
  logic [7:0] rx_data;
  int         checks = 0;
  int         errors = 0;

  fifo_bus_ctrl dut (
    .clk(clk), .reset(reset), .clear(clear), .fifo_rxf(fifo_rxf), .fifo_txe(fifo_txe),
    .fifo_rd(fifo_rd), .fifo_wr(fifo_wr), .fifo_data(fifo_data), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_take(rx_take), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ack(tx_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO model drives the bus only while RD# is low
  assign fifo_data = (fifo_rd == 1'b0) ? bus_val : 8'hzz;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task wait_idle;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) tick;
    checks++;
    if (busy !== 1'b0) begin $display("FAIL idle_timeout: busy=%b want 0", busy); errors++; end
  endtask

  task wait_rd_low;
    for (int i = 0; i < 40 && fifo_rd !== 1'b0; i++) tick;
    checks++;
    if (fifo_rd !== 1'b0) begin $display("FAIL rd_timeout: fifo_rd=%b want 0", fifo_rd); errors++; end
  endtask

  task test_reset;
    reset = 1'b1; clear = 1'b0; fifo_rxf = 1'b1; fifo_txe = 1'b1;
    rx_take = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; bus_val = 8'h00;
    tick; tick;
    checks++;
    if ({fifo_rd, fifo_wr, dut.oe, rx_valid, tx_ack, busy} !== 6'b100000) begin
      $display("FAIL reset_ctrl: rd/wr/oe/rxv/ack/busy=%b want 100000",
               {fifo_rd, fifo_wr, dut.oe, rx_valid, tx_ack, busy});
      errors++;
    end
    checks++;
    if (rx_data !== 8'h00) begin $display("FAIL reset_rx_data: got %h want 00", rx_data); errors++; end
    reset = 1'b0;
    tick;
  endtask

  task test_rx_byte;
    fifo_rxf = 1'b0; bus_val = 8'h8D;
    tick;  // E
    checks++;
    if (fifo_rd !== 1'b1) begin $display("FAIL rx_lat_e0: rd=%b want 1", fifo_rd); errors++; end
    tick;  // E+1
    checks++;
    if (fifo_rd !== 1'b1) begin $display("FAIL rx_lat_e1: rd=%b want 1", fifo_rd); errors++; end
    tick;  // E+2
    checks++;
    if ({fifo_rd, busy} !== 2'b01) begin $display("FAIL rx_rd_start: rd/busy=%b want 01", {fifo_rd, busy}); errors++; end
    tick;  // E+3
    checks++;
    if (fifo_rd !== 1'b0) begin $display("FAIL rx_rd_hold: rd=%b want 0", fifo_rd); errors++; end
    fifo_rxf = 1'b1;
    tick;  // E+4
    checks++;
    if ({fifo_rd, rx_valid, rx_data} !== {2'b11, 8'h8D}) begin
      $display("FAIL rx_capture: rd=%b rxv=%b data=%h want 1 1 8d", fifo_rd, rx_valid, rx_data);
      errors++;
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if ({fifo_rd, busy} !== 2'b11) begin $display("FAIL rx_rec%0d: rd/busy=%b want 11", i, {fifo_rd, busy}); errors++; end
    end
    tick;
    checks++;
    if (busy !== 1'b0) begin $display("FAIL rx_rec_end: busy=%b want 0", busy); errors++; end
  endtask

  task test_full;
    int bad;
    bad = 0;
    fifo_rxf = 1'b0; bus_val = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (fifo_rd !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin $display("FAIL full_no_strobe: low rd clocks=%0d want 0", bad); errors++; end
    rx_take = 1'b1;
    tick;
    rx_take = 1'b0;
    checks++;
    if ({rx_valid, fifo_rd} !== 2'b00) begin $display("FAIL full_take_read: rxv/rd=%b want 00", {rx_valid, fifo_rd}); errors++; end
    tick;
    fifo_rxf = 1'b1;
    tick;
    checks++;
    if ({fifo_rd, rx_valid, rx_data} !== {2'b11, 8'h3C}) begin
      $display("FAIL full_second_byte: rd=%b rxv=%b data=%h want 1 1 3c", fifo_rd, rx_valid, rx_data);
      errors++;
    end
    wait_idle;
    rx_take = 1'b1;
    tick;
    rx_take = 1'b0;
    checks++;
    if ({rx_valid, rx_data} !== {1'b0, 8'h3C}) begin
      $display("FAIL take_keeps_data: rxv=%b data=%h want 0 3c", rx_valid, rx_data);
      errors++;
    end
  endtask

  task test_clear;
    fifo_rxf = 1'b0; bus_val = 8'h55;
    wait_rd_low;
    tick;
    clear = 1'b1; fifo_rxf = 1'b1;
    tick;  // capture edge
    clear = 1'b0;
    checks++;
    if ({rx_valid, fifo_rd} !== 2'b01) begin $display("FAIL clear_collision: rxv/rd=%b want 01", {rx_valid, fifo_rd}); errors++; end
    wait_idle;
    fifo_rxf = 1'b0; bus_val = 8'hA7;
    wait_rd_low;
    fifo_rxf = 1'b1;
    wait_idle;
    checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'hA7}) begin
      $display("FAIL clear_prep: rxv=%b data=%h want 1 a7", rx_valid, rx_data);
      errors++;
    end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin $display("FAIL clear_idle: rxv=%b want 0", rx_valid); errors++; end
  endtask

  task test_tx_byte;
    fifo_txe = 1'b0;
    tick; tick; tick;
    tx_data = 8'h0B; tx_valid = 1'b1;
    tick;  // E
    checks++;
    if ({dut.oe, fifo_wr, fifo_data} !== {2'b10, 8'h0B}) begin
      $display("FAIL tx_setup: oe=%b wr=%b bus=%h want 1 0 0b", dut.oe, fifo_wr, fifo_data);
      errors++;
    end
    tx_data = 8'hEE;
    tick;  // E+1
    checks++;
    if ({fifo_wr, dut.oe, tx_ack, fifo_data} !== {3'b110, 8'h0B}) begin
      $display("FAIL tx_wr_rise: wr=%b oe=%b ack=%b bus=%h want 1 1 0 0b", fifo_wr, dut.oe, tx_ack, fifo_data);
      errors++;
    end
    tick;  // E+2
    checks++;
    if ({fifo_wr, tx_ack} !== 2'b10) begin $display("FAIL tx_wr_hold: wr/ack=%b want 10", {fifo_wr, tx_ack}); errors++; end
    tick;  // E+3
    checks++;
    if ({fifo_wr, tx_ack, dut.oe, fifo_data} !== {3'b011, 8'h0B}) begin
      $display("FAIL tx_hold: wr=%b ack=%b oe=%b bus=%h want 0 1 1 0b", fifo_wr, tx_ack, dut.oe, fifo_data);
      errors++;
    end
    tx_valid = 1'b0;
    tick;  // E+4
    checks++;
    if ({dut.oe, tx_ack, fifo_wr, busy} !== 4'b0001) begin
      $display("FAIL tx_release: oe/ack/wr/busy=%b want 0001", {dut.oe, tx_ack, fifo_wr, busy});
      errors++;
    end
    wait_idle;
  endtask

  task test_tie;
    bit   g [4];
    bit   exp_g [4];
    int   ng, overlap;
    logic prev_rd, prev_oe;
    exp_g[0] = 1'b1; exp_g[1] = 1'b0; exp_g[2] = 1'b1; exp_g[3] = 1'b0;
    for (int k = 0; k < 4; k++) g[k] = 1'b0;
    ng = 0; overlap = 0; prev_rd = 1'b1; prev_oe = 1'b0;
    fifo_txe = 1'b1;
    tick; tick; tick;
    fifo_rxf = 1'b0; fifo_txe = 1'b0; bus_val = 8'hC3; tx_data = 8'h5A; tx_valid = 1'b1;
    for (int i = 0; i < 100 && ng < 4; i++) begin
      tick;
      if (fifo_rd === 1'b0 && dut.oe === 1'b1) overlap++;
      if (prev_rd === 1'b1 && fifo_rd === 1'b0) begin g[ng] = 1'b1; ng++; end
      else if (prev_oe === 1'b0 && dut.oe === 1'b1) begin g[ng] = 1'b0; ng++; end
      prev_rd = fifo_rd; prev_oe = dut.oe;
      rx_take = rx_valid;
    end
    fifo_rxf = 1'b1;
    checks++;
    if (ng !== 4) begin $display("FAIL tie_grants: got %0d grants want 4", ng); errors++; end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (g[k] !== exp_g[k]) begin $display("FAIL tie_order%0d: rx_grant=%b want %b", k, g[k], exp_g[k]); errors++; end
    end
    for (int i = 0; i < 30; i++) begin
      tick;
      if (fifo_rd === 1'b0 && dut.oe === 1'b1) overlap++;
      if (tx_ack === 1'b1) tx_valid = 1'b0;
      rx_take = rx_valid;
    end
    rx_take = 1'b0;
    checks++;
    if (overlap !== 0) begin $display("FAIL tie_overlap: clocks=%0d want 0", overlap); errors++; end
    checks++;
    if (tx_valid !== 1'b0) begin $display("FAIL tie_last_ack: tx_valid still %b want 0", tx_valid); errors++; end
    wait_idle;
  endtask

  task test_reset_mid_write;
    int acks, bad;
    acks = 0; bad = 0;
    fifo_rxf = 1'b1; tx_data = 8'h6E; tx_valid = 1'b1;
    for (int i = 0; i < 20 && fifo_wr !== 1'b1; i++) tick;
    checks++;
    if (fifo_wr !== 1'b1) begin $display("FAIL rst_wr_timeout: wr=%b want 1", fifo_wr); errors++; end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if ({fifo_wr, dut.oe, tx_ack, fifo_rd, busy} !== 5'b00010) begin
      $display("FAIL rst_mid_write: wr/oe/ack/rd/busy=%b want 00010", {fifo_wr, dut.oe, tx_ack, fifo_rd, busy});
      errors++;
    end
    for (int i = 0; i < 40; i++) begin
      tick;
      if (tx_ack === 1'b1) begin acks++; tx_valid = 1'b0; end
      if (fifo_wr === 1'b1 && fifo_data !== 8'h6E) bad++;
    end
    checks++;
    if (acks !== 1) begin $display("FAIL rst_resend_ack: acks=%0d want 1", acks); errors++; end
    checks++;
    if (bad !== 0) begin $display("FAIL rst_resend_data: bad clocks=%0d want 0", bad); errors++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_rx_byte;
    test_full;
    test_clear;
    test_tx_byte;
    test_tie;
    test_reset_mid_write;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
